// File: rtl/upower_operand_fetch_pkg.sv
// Shared constants, field positions and the registered operand bundle
// for the uPOWER operand fetch stage.
package upower_operand_fetch_pkg;

  localparam logic [5:0] OP_XFORM = 6'd31;
  localparam logic [5:0] OP_ADDI  = 6'd14;

  localparam logic [8:0] XO_ADD  = 9'd266;
  localparam logic [8:0] XO_SUBF = 9'd40;
  localparam logic [8:0] XO_AND  = 9'd28;
  localparam logic [8:0] XO_NAND = 9'd476;
  localparam logic [8:0] XO_OR   = 9'd444;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_XFORM = 2'b10;

  // Bit positions in the 32-bit word (bit 31 is architectural bit 0).
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RT_HI  = 25;
  localparam int RT_LO  = 21;
  localparam int RA_HI  = 20;
  localparam int RA_LO  = 16;
  localparam int RB_HI  = 15;
  localparam int RB_LO  = 11;
  localparam int XO_HI  = 9;
  localparam int XO_LO  = 1;
  localparam int SI_HI  = 15;
  localparam int SI_LO  = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  aluop;
    logic [5:0]  opcode;
    logic [8:0]  xo;
    logic [4:0]  dest;
    logic        illegal;
  } bundle_t;

  function automatic logic [63:0] sext16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

endpackage

// File: rtl/upower_regfile.sv
// 32x64 general purpose register file: two asynchronous read ports,
// one synchronous write port, synchronous clear on reset.
module upower_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr0,
  output logic [63:0] rdata0,
  input  logic [4:0]  raddr1,
  output logic [63:0] rdata1,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [63:0] wdata
);

  logic [63:0] mem [32];

  // Reset takes priority so a write strobe in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/upower_operand_fetch.sv
// uPOWER operand fetch: decodes an instruction, reads and forwards its
// source operands, and registers the ALU operand bundle.
module upower_operand_fetch
  import upower_operand_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [63:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic [1:0]  ALUOp,
  output logic [5:0]  OpCode,
  output logic [8:0]  XO,
  output logic [4:0]  dest,
  output logic        illegal
);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; a held bundle (out_valid && !out_ready) never changes, and the
  // input side is ready whenever the output register is empty or draining.

  logic [5:0]  f_opc;
  logic [4:0]  f_rt, f_ra, f_rb;
  logic [8:0]  f_xo;
  logic [15:0] f_si;

  assign f_opc = instr[OPC_HI:OPC_LO];
  assign f_rt  = instr[RT_HI:RT_LO];
  assign f_ra  = instr[RA_HI:RA_LO];
  assign f_rb  = instr[RB_HI:RB_LO];
  assign f_xo  = instr[XO_HI:XO_LO];
  assign f_si  = instr[SI_HI:SI_LO];

  logic [4:0]  rd0_idx, rd1_idx;
  logic [63:0] rd0_raw, rd1_raw, rd0_val, rd1_val;

  always_comb begin
    rd0_idx = f_ra;
    rd1_idx = f_rb;
    if (f_opc == OP_XFORM) begin
      if (f_xo == XO_SUBF) begin
        rd0_idx = f_rb;
        rd1_idx = f_ra;
      end else if (f_xo != XO_ADD) begin
        rd0_idx = f_rt;
        rd1_idx = f_rb;
      end
    end
  end

  upower_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr0 (rd0_idx),
    .rdata0 (rd0_raw),
    .raddr1 (rd1_idx),
    .rdata1 (rd1_raw),
    .wen    (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // A write landing on this edge must be seen by the instruction captured on it.
  assign rd0_val = (wb_en && (wb_addr == rd0_idx)) ? wb_data : rd0_raw;
  assign rd1_val = (wb_en && (wb_addr == rd1_idx)) ? wb_data : rd1_raw;

  bundle_t nxt, cur;

  always_comb begin
    nxt        = '0;
    nxt.opcode = f_opc;
    nxt.xo     = f_xo;
    if (f_opc == OP_XFORM) begin
      nxt.aluop = ALU_XFORM;
      nxt.a     = rd0_val;
      nxt.b     = rd1_val;
      nxt.dest  = ((f_xo == XO_ADD) || (f_xo == XO_SUBF)) ? f_rt : f_ra;
    end else if (f_opc == OP_ADDI) begin
      nxt.aluop = ALU_ADD;
      nxt.a     = (f_ra == 5'd0) ? 64'd0 : rd0_val;
      nxt.b     = sext16(f_si);
      nxt.dest  = f_rt;
    end else begin
      nxt.illegal = 1'b1;
    end
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      cur       <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) cur <= nxt;
    end
  end

  assign a       = cur.a;
  assign b       = cur.b;
  assign ALUOp   = cur.aluop;
  assign OpCode  = cur.opcode;
  assign XO      = cur.xo;
  assign dest    = cur.dest;
  assign illegal = cur.illegal;

endmodule

// File: tb/tb_upower_operand_fetch.sv
// Directed bench for upower_operand_fetch: a vector table plus hand-written
// stall, forwarding and reset sequences.
module tb_upower_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] a, b;
  logic [1:0]  ALUOp;
  logic [5:0]  OpCode;
  logic [8:0]  XO;
  logic [4:0]  dest;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  upower_operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .ALUOp     (ALUOp),
    .OpCode    (OpCode),
    .XO        (XO),
    .dest      (dest),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [1:0]  alu;
    logic [4:0]  dest;
    logic        ill;
    logic        chk_dest;
  } vec_t;

  vec_t vt[11];

  function automatic logic [31:0] xform(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input logic [8:0] xo);
    return {op, rt, ra, rb, 1'b0, xo, 1'b0};
  endfunction

  function automatic logic [31:0] dform(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] ra, input logic [15:0] si);
    return {op, rt, ra, si};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [63:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  // Issue one instruction with out_ready high; outputs are sampled after the edge.
  task automatic issue(input logic [31:0] ins);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = ins;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0;
    wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready",  {63'd0, in_ready},  64'd1);
    check("reset_a",       a, 64'd0);
    check("reset_b",       b, 64'd0);
    check("reset_aluop",   {62'd0, ALUOp}, 64'd0);
    check("reset_opcode",  {58'd0, OpCode}, 64'd0);
    check("reset_xo",      {55'd0, XO}, 64'd0);
    check("reset_dest",    {59'd0, dest}, 64'd0);
    check("reset_illegal", {63'd0, illegal}, 64'd0);

    wb_write(5'd0,  64'h55);
    wb_write(5'd1,  64'h101);
    wb_write(5'd2,  64'h11);
    wb_write(5'd3,  64'h33);
    wb_write(5'd8,  64'hA);
    wb_write(5'd9,  64'd7);
    wb_write(5'd10, 64'd1);

    vt[0]  = '{xform(6'd31, 5'd1, 5'd3, 5'd2, 9'd28),  64'h101, 64'h11, 2'b10, 5'd3, 1'b0, 1'b1};
    vt[1]  = '{xform(6'd31, 5'd4, 5'd10, 5'd9, 9'd40), 64'd7, 64'd1, 2'b10, 5'd4, 1'b0, 1'b1};
    vt[2]  = '{xform(6'd31, 5'd11, 5'd1, 5'd2, 9'd266), 64'h101, 64'h11, 2'b10, 5'd11, 1'b0, 1'b1};
    vt[3]  = '{xform(6'd31, 5'd3, 5'd12, 5'd8, 9'd444), 64'h33, 64'hA, 2'b10, 5'd12, 1'b0, 1'b1};
    vt[4]  = '{xform(6'd31, 5'd2, 5'd13, 5'd1, 9'd476), 64'h11, 64'h101, 2'b10, 5'd13, 1'b0, 1'b1};
    vt[5]  = '{dform(6'd14, 5'd5, 5'd0, 16'hFFFF), 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 5'd5, 1'b0, 1'b1};
    vt[6]  = '{dform(6'd14, 5'd5, 5'd8, 16'hFFFF), 64'hA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 5'd5, 1'b0, 1'b1};
    vt[7]  = '{dform(6'd14, 5'd6, 5'd3, 16'h7FFF), 64'h33, 64'h7FFF, 2'b00, 5'd6, 1'b0, 1'b1};
    vt[8]  = '{xform(6'd31, 5'd0, 5'd14, 5'd0, 9'd28), 64'h55, 64'h55, 2'b10, 5'd14, 1'b0, 1'b1};
    vt[9]  = '{xform(6'h3F, 5'd1, 5'd2, 5'd3, 9'd266), 64'd0, 64'd0, 2'b00, 5'd0, 1'b1, 1'b0};
    vt[10] = '{dform(6'd7, 5'd1, 5'd2, 16'h1234), 64'd0, 64'd0, 2'b00, 5'd0, 1'b1, 1'b0};

    // Back-to-back: each edge loads the next table entry.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      instr = vt[i].instr;
      tick();
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_a", i), a, vt[i].ea);
      check($sformatf("v%0d_b", i), b, vt[i].eb);
      check($sformatf("v%0d_aluop", i), {62'd0, ALUOp}, {62'd0, vt[i].alu});
      check($sformatf("v%0d_opcode", i), {58'd0, OpCode}, {58'd0, vt[i].instr[31:26]});
      check($sformatf("v%0d_xo", i), {55'd0, XO}, {55'd0, vt[i].instr[9:1]});
      check($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, vt[i].ill});
      if (vt[i].chk_dest) check($sformatf("v%0d_dest", i), {59'd0, dest}, {59'd0, vt[i].dest});
    end
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", {63'd0, out_valid}, 64'd0);

    wb_write(5'd1, 64'd1);
    wb_write(5'd2, 64'd7);
    issue(xform(6'd31, 5'd4, 5'd1, 5'd2, 9'd40));
    check("subf_a", a, 64'd7);
    check("subf_b", b, 64'd1);
    check("subf_xo", {55'd0, XO}, 64'd40);
    check("subf_dest", {59'd0, dest}, 64'd4);

    wb_write(5'd1, 64'hA);
    issue(dform(6'd14, 5'd5, 5'd1, 16'hFFFF));
    check("addi_r1_a", a, 64'hA);
    check("addi_r1_b", b, 64'hFFFF_FFFF_FFFF_FFFF);

    // Write-back forwarded into the capture cycle.
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 64'h1234;
    issue(xform(6'd31, 5'd7, 5'd6, 5'd2, 9'd266));
    wb_en = 1'b0;
    check("fwd_a", a, 64'h1234);
    check("fwd_b", b, 64'd7);
    check("fwd_dest", {59'd0, dest}, 64'd7);

    // Stall: held bundle ignores a later write to its source.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = xform(6'd31, 5'd8, 5'd6, 5'd6, 9'd266);
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 64'h5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_en = 1'b0;
      check($sformatf("stall%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("stall%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("stall%0d_a", i), a, 64'h1234);
      check($sformatf("stall%0d_dest", i), {59'd0, dest}, 64'd7);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("release_valid", {63'd0, out_valid}, 64'd1);
    check("release_a", a, 64'h5678);
    check("release_b", b, 64'h5678);
    check("release_dest", {59'd0, dest}, 64'd8);
    tick();
    check("release_drain", {63'd0, out_valid}, 64'd0);

    // Illegal held, then reset with a write strobe that must be dropped.
    out_ready = 1'b0;
    issue(xform(6'h3F, 5'd0, 5'd0, 5'd0, 9'd0));
    out_ready = 1'b0;
    check("illegal_valid", {63'd0, out_valid}, 64'd1);
    check("illegal_flag", {63'd0, illegal}, 64'd1);
    tick();
    check("illegal_held", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h99;
    tick();
    rst = 1'b0;
    wb_en = 1'b0;
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_illegal", {63'd0, illegal}, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 32; i += 2) begin
      issue(xform(6'd31, 5'(i), 5'd20, 5'(i + 1), 9'd28));
      check($sformatf("rst_r%0d", i), a, 64'd0);
      check($sformatf("rst_r%0d", i + 1), b, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
